// File: rtl/axi_10g_ethernet_0_tx_arbiter_if.sv
// axi_10g_ethernet_0_tx_arbiter_if
// One 64-bit AXI-Stream link (data, byte keep, last, valid/ready).
//   master : drives tdata/tkeep/tvalid/tlast, samples tready
//   slave  : samples tdata/tkeep/tvalid/tlast, drives tready
interface axi_10g_ethernet_0_tx_arbiter_if;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tvalid;
  logic        tlast;
  logic        tready;

  modport master (output tdata, output tkeep, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tkeep, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axi_10g_ethernet_0_tx_arbiter.sv
// axi_10g_ethernet_0_tx_arbiter
// Shares the 10G MAC TX AXI-Stream between the grant-style ARP reply
// generator (G) and two plain AXI-Stream sources (A, B). Ownership changes
// only at frame boundaries: G has fixed priority, A and B alternate. G beats
// go through a small skid FIFO because G cannot be stalled once a beat is in
// flight.
//
// Ports
//   aclk, aresetn      clock, asynchronous active-low reset
//   g_req / g_grant    G request (captured as pending) / registered grant
//   g_t*               G beat, arrives one cycle after a grant
//   g_done             G frame-complete pulse (informational)
//   a, b               source streams (slave side)
//   m                  stream to the MAC (master side)
//   cnt_g/cnt_a/cnt_b  wrapping completed-frame counters
//   err_timeout        one-cycle pulse when a G grant is abandoned
//   err_overflow       sticky; a G beat found the FIFO full
//
// state | meaning
// IDLE  | no owner; one-cycle arbitration decision, no beat passed
// OWN_A | source A passes straight through to the MAC
// OWN_B | source B passes straight through to the MAC
// OWN_G | G granted; the MAC is fed from the skid FIFO
module axi_10g_ethernet_0_tx_arbiter #(
  parameter int FIFO_DEPTH    = 4,
  parameter int GRANT_TIMEOUT = 64,
  parameter int CNT_W         = 16
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic                            g_req,
  output logic                            g_grant,
  input  logic [63:0]                     g_tdata,
  input  logic [7:0]                      g_tkeep,
  input  logic                            g_tvalid,
  input  logic                            g_tlast,
  input  logic                            g_done,
  axi_10g_ethernet_0_tx_arbiter_if.slave  a,
  axi_10g_ethernet_0_tx_arbiter_if.slave  b,
  axi_10g_ethernet_0_tx_arbiter_if.master m,
  output logic [CNT_W-1:0]                cnt_g,
  output logic [CNT_W-1:0]                cnt_a,
  output logic [CNT_W-1:0]                cnt_b,
  output logic                            err_timeout,
  output logic                            err_overflow
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int TMR_W = $clog2(GRANT_TIMEOUT + 1);
  localparam logic [PTR_W:0]   DEPTH_V   = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W+1:0] GRANT_LIM = (PTR_W+2)'(FIFO_DEPTH - 2);
  localparam logic [TMR_W-1:0] TMR_LOAD  = TMR_W'(GRANT_TIMEOUT - 1);
  localparam logic RR_A = 1'b0;
  localparam logic RR_B = 1'b1;

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B, OWN_G} state_t;

  state_t           state, state_nxt;
  logic             rr_last, rr_nxt;
  logic             g_pend, g_pend_nxt;
  logic             tl_written, tl_written_nxt;  // tlast beat of this grant already in the FIFO
  logic             beat_seen, beat_seen_nxt;    // any beat written since the grant started
  logic [TMR_W-1:0] tmr, tmr_nxt;
  logic             g_grant_nxt, err_timeout_nxt;
  logic             inc_g, inc_a, inc_b;

  logic [72:0]      mem [FIFO_DEPTH];
  logic [PTR_W:0]   wr_ptr, rd_ptr, fill, fill_nxt;
  logic [PTR_W+1:0] proj;
  logic [72:0]      head;
  logic             fifo_empty, fifo_full, push, pop, drop;

  // Frame end is taken from the tlast beat itself; g_done carries no extra information.
  logic g_done_unused;
  assign g_done_unused = g_done;

  assign fill       = wr_ptr - rd_ptr;
  assign fifo_empty = (fill == '0);
  assign fifo_full  = (fill == DEPTH_V);
  assign head       = mem[rd_ptr[PTR_W-1:0]];
  assign push       = (state == OWN_G) && g_tvalid && !fifo_full;
  assign drop       = g_tvalid && fifo_full;
  assign pop        = (state == OWN_G) && !fifo_empty && m.tready;
  assign fill_nxt   = fill + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
  // A grant now produces a beat next cycle, so the beat already promised by
  // the current grant is counted before deciding on another one.
  assign proj       = (PTR_W+2)'(fill_nxt) + (PTR_W+2)'(g_grant);

  always_comb begin
    state_nxt       = state;
    rr_nxt          = rr_last;
    g_pend_nxt      = g_pend | g_req;
    tl_written_nxt  = tl_written | (push & g_tlast);
    beat_seen_nxt   = beat_seen | push;
    tmr_nxt         = tmr;
    err_timeout_nxt = 1'b0;
    inc_g           = 1'b0;
    inc_a           = 1'b0;
    inc_b           = 1'b0;
    case (state)
      IDLE: begin
        if (g_pend) begin
          state_nxt      = OWN_G;
          g_pend_nxt     = 1'b0;
          tl_written_nxt = 1'b0;
          beat_seen_nxt  = 1'b0;
          tmr_nxt        = TMR_LOAD;
        end else if (a.tvalid && (!b.tvalid || rr_last == RR_B)) begin
          state_nxt = OWN_A;
        end else if (b.tvalid) begin
          state_nxt = OWN_B;
        end
      end
      OWN_A: begin
        if (a.tvalid && m.tready && a.tlast) begin
          inc_a     = 1'b1;
          rr_nxt    = RR_A;
          state_nxt = IDLE;
        end
      end
      OWN_B: begin
        if (b.tvalid && m.tready && b.tlast) begin
          inc_b     = 1'b1;
          rr_nxt    = RR_B;
          state_nxt = IDLE;
        end
      end
      OWN_G: begin
        if (pop && head[0]) begin
          inc_g     = 1'b1;
          state_nxt = IDLE;
        end else if (!beat_seen && !push) begin
          if (tmr == '0) begin
            err_timeout_nxt = 1'b1;
            state_nxt       = IDLE;
          end else begin
            tmr_nxt = tmr - TMR_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    g_grant_nxt = (state_nxt == OWN_G) && !tl_written_nxt && (proj <= GRANT_LIM);
  end

  always_comb begin
    m.tvalid = 1'b0;
    m.tdata  = '0;
    m.tkeep  = '0;
    m.tlast  = 1'b0;
    a.tready = 1'b0;
    b.tready = 1'b0;
    case (state)
      OWN_A: begin
        a.tready = m.tready;
        if (a.tvalid) begin
          m.tvalid = 1'b1;
          m.tdata  = a.tdata;
          m.tkeep  = a.tkeep;
          m.tlast  = a.tlast;
        end
      end
      OWN_B: begin
        b.tready = m.tready;
        if (b.tvalid) begin
          m.tvalid = 1'b1;
          m.tdata  = b.tdata;
          m.tkeep  = b.tkeep;
          m.tlast  = b.tlast;
        end
      end
      OWN_G: begin
        if (!fifo_empty) begin
          m.tvalid = 1'b1;
          m.tdata  = head[72:9];
          m.tkeep  = head[8:1];
          m.tlast  = head[0];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (push) mem[wr_ptr[PTR_W-1:0]] <= {g_tdata, g_tkeep, g_tlast};
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state        <= IDLE;
      rr_last      <= RR_B;
      g_pend       <= 1'b0;
      tl_written   <= 1'b0;
      beat_seen    <= 1'b0;
      tmr          <= '0;
      g_grant      <= 1'b0;
      err_timeout  <= 1'b0;
      err_overflow <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      cnt_g        <= '0;
      cnt_a        <= '0;
      cnt_b        <= '0;
    end else begin
      state       <= state_nxt;
      rr_last     <= rr_nxt;
      g_pend      <= g_pend_nxt;
      tl_written  <= tl_written_nxt;
      beat_seen   <= beat_seen_nxt;
      tmr         <= tmr_nxt;
      g_grant     <= g_grant_nxt;
      err_timeout <= err_timeout_nxt;
      if (drop)  err_overflow <= 1'b1;
      if (push)  wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (pop)   rd_ptr <= rd_ptr + (PTR_W+1)'(1);
      if (inc_g) cnt_g <= cnt_g + CNT_W'(1);
      if (inc_a) cnt_a <= cnt_a + CNT_W'(1);
      if (inc_b) cnt_b <= cnt_b + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_axi_10g_ethernet_0_tx_arbiter.sv
// tb_axi_10g_ethernet_0_tx_arbiter
// Directed sequence with random frame contents. Source models drive A, B and
// G; a monitor records every MAC beat; the expected stream is built from the
// arbitration rules and compared beat by beat.
module tb_axi_10g_ethernet_0_tx_arbiter;
  localparam int DEPTH = 4;
  localparam int TMO   = 64;
  localparam int CW    = 16;
  localparam int SRC_A = 0;
  localparam int SRC_B = 1;
  localparam int SRC_G = 2;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } beat_t;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          g_req = 1'b0;
  logic          g_grant;
  logic [63:0]   g_tdata = '0;
  logic [7:0]    g_tkeep = '0;
  logic          g_tvalid = 1'b0;
  logic          g_tlast = 1'b0;
  logic          g_done = 1'b0;
  logic [CW-1:0] cnt_g, cnt_a, cnt_b;
  logic          err_timeout, err_overflow;

  axi_10g_ethernet_0_tx_arbiter_if a_if ();
  axi_10g_ethernet_0_tx_arbiter_if b_if ();
  axi_10g_ethernet_0_tx_arbiter_if m_if ();

  always #5 aclk = ~aclk;

  axi_10g_ethernet_0_tx_arbiter #(
    .FIFO_DEPTH(DEPTH), .GRANT_TIMEOUT(TMO), .CNT_W(CW)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .g_req(g_req), .g_grant(g_grant),
    .g_tdata(g_tdata), .g_tkeep(g_tkeep), .g_tvalid(g_tvalid), .g_tlast(g_tlast),
    .g_done(g_done),
    .a(a_if), .b(b_if), .m(m_if),
    .cnt_g(cnt_g), .cnt_a(cnt_a), .cnt_b(cnt_b),
    .err_timeout(err_timeout), .err_overflow(err_overflow)
  );

  int n_cmp = 0;
  int n_err = 0;

  beat_t a_q[$], b_q[$], g_q[$];     // beats still to be driven by each source
  beat_t pa_q[$], pb_q[$], pg_q[$];  // generated beats not yet placed in the expected stream
  beat_t exp_q[$], obs_q[$];

  logic [CW-1:0] exp_cnt_g = '0, exp_cnt_a = '0, exp_cnt_b = '0;
  int            model_rr = SRC_B;

  int       cyc = 0;
  bit       prev_grant = 1'b0;
  bit       g_last_prev = 1'b0;
  bit       bp_en = 1'b0;
  logic [3:0] bp_pat = 4'b1001;      // ready 1,0,0,1 repeating
  int       g_emit = 0, m_out = 0, max_occ = 0;
  bit       in_frame = 1'b0;
  int       last_end_cyc = 0;
  int       gaps[$];
  bit       grant_seen = 1'b1;
  int       grant_cyc = 0, tmo_cyc = 0, tmo_pulses = 0;
  logic     tmo_grant = 1'b0;

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge aclk);
    #3;
  endtask

  task automatic gen(input int src, input int n, input logic [7:0] lk);
    beat_t bt;
    for (int i = 0; i < n; i++) begin
      bt.d = {$urandom, $urandom};
      bt.k = (i == n-1) ? lk : 8'hFF;
      bt.l = (i == n-1);
      if (src == SRC_A) begin a_q.push_back(bt); pa_q.push_back(bt); end
      else if (src == SRC_B) begin b_q.push_back(bt); pb_q.push_back(bt); end
      else begin g_q.push_back(bt); pg_q.push_back(bt); end
    end
  endtask

  // Appends the next whole frame of a source to the expected stream.
  task automatic expect_frame(input int src);
    beat_t bt;
    int    guard;
    bt = '0;
    guard = 0;
    while (!bt.l && guard < 64) begin
      guard++;
      if (src == SRC_A) bt = pa_q.pop_front();
      else if (src == SRC_B) bt = pb_q.pop_front();
      else bt = pg_q.pop_front();
      exp_q.push_back(bt);
    end
    if (src == SRC_A) begin exp_cnt_a++; model_rr = SRC_A; end
    else if (src == SRC_B) begin exp_cnt_b++; model_rr = SRC_B; end
    else exp_cnt_g++;
  endtask

  // A and B both offering frames continuously: they alternate, starting
  // with whichever was not served last.
  task automatic model_arbitrate(input int na, input int nb);
    while (na > 0 || nb > 0) begin
      if (na > 0 && (nb == 0 || model_rr == SRC_B)) begin expect_frame(SRC_A); na--; end
      else begin expect_frame(SRC_B); nb--; end
    end
  endtask

  task automatic wait_beats(input int n, input int budget);
    int k;
    k = 0;
    while (obs_q.size() < n && k < budget) begin
      step();
      k++;
    end
  endtask

  task automatic compare_stream(input string tag);
    check({tag, "_len"}, 80'(obs_q.size()), 80'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check(tag, 80'(obs_q[i]), 80'(exp_q[i]));
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_cnt_g"}, 80'(cnt_g), 80'(exp_cnt_g));
    check({tag, "_cnt_a"}, 80'(cnt_a), 80'(exp_cnt_a));
    check({tag, "_cnt_b"}, 80'(cnt_b), 80'(exp_cnt_b));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_g_grant"}, 80'(g_grant), 80'(0));
    check({tag, "_a_tready"}, 80'(a_if.tready), 80'(0));
    check({tag, "_b_tready"}, 80'(b_if.tready), 80'(0));
    check({tag, "_m_tvalid"}, 80'(m_if.tvalid), 80'(0));
    check({tag, "_m_beat"}, 80'({m_if.tdata, m_if.tkeep, m_if.tlast}), 80'(0));
    check({tag, "_err_timeout"}, 80'(err_timeout), 80'(0));
    check({tag, "_err_overflow"}, 80'(err_overflow), 80'(0));
    check_counters(tag);
  endtask

  // Source models and MAC monitor: drive on the falling edge, sample 1 ns later.
  initial begin
    beat_t bt;
    a_if.tvalid = 1'b0; a_if.tdata = '0; a_if.tkeep = '0; a_if.tlast = 1'b0;
    b_if.tvalid = 1'b0; b_if.tdata = '0; b_if.tkeep = '0; b_if.tlast = 1'b0;
    m_if.tready = 1'b0;
    forever begin
      @(negedge aclk);
      cyc++;
      if (a_q.size() > 0) begin
        a_if.tvalid = 1'b1;
        {a_if.tdata, a_if.tkeep, a_if.tlast} = a_q[0];
      end else begin
        a_if.tvalid = 1'b0; a_if.tdata = '0; a_if.tkeep = '0; a_if.tlast = 1'b0;
      end
      if (b_q.size() > 0) begin
        b_if.tvalid = 1'b1;
        {b_if.tdata, b_if.tkeep, b_if.tlast} = b_q[0];
      end else begin
        b_if.tvalid = 1'b0; b_if.tdata = '0; b_if.tkeep = '0; b_if.tlast = 1'b0;
      end
      g_done = g_last_prev;
      g_last_prev = 1'b0;
      if (prev_grant && g_q.size() > 0) begin
        bt = g_q.pop_front();
        g_tvalid = 1'b1;
        {g_tdata, g_tkeep, g_tlast} = bt;
        g_last_prev = bt.l;
        g_emit++;
      end else begin
        g_tvalid = 1'b0; g_tdata = '0; g_tkeep = '0; g_tlast = 1'b0;
      end
      m_if.tready = bp_en ? bp_pat[cyc % 4] : 1'b1;
      #1;
      prev_grant = g_grant;
      if (a_if.tvalid && a_if.tready) void'(a_q.pop_front());
      if (b_if.tvalid && b_if.tready) void'(b_q.pop_front());
      if (m_if.tvalid && m_if.tready) begin
        obs_q.push_back(beat_t'({m_if.tdata, m_if.tkeep, m_if.tlast}));
        m_out++;
        if (!in_frame) begin
          gaps.push_back(cyc - last_end_cyc);
          in_frame = 1'b1;
        end
        if (m_if.tlast) begin
          in_frame = 1'b0;
          last_end_cyc = cyc;
        end
      end
      if (g_emit - m_out > max_occ) max_occ = g_emit - m_out;
      if (g_grant && !grant_seen) begin
        grant_seen = 1'b1;
        grant_cyc = cyc;
      end
      if (err_timeout) begin
        tmo_pulses++;
        tmo_cyc = cyc;
        tmo_grant = g_grant;
      end
    end
  end

  initial begin
    // Reset values
    repeat (3) step();
    check_reset_outputs("reset");
    aresetn = 1'b1;
    step();

    // G only
    g_emit = 0; m_out = 0; max_occ = 0;
    gen(SRC_G, 8, 8'h0F);
    g_req = 1'b1;
    step();
    g_req = 1'b0;
    expect_frame(SRC_G);
    wait_beats(8, 100);
    repeat (3) step();
    compare_stream("g_only");
    check_counters("g_only");
    check("g_only_grant_idle", 80'(g_grant), 80'(0));
    check("g_only_mvalid_idle", 80'(m_if.tvalid), 80'(0));

    // G with backpressure
    g_emit = 0; m_out = 0; max_occ = 0;
    bp_en = 1'b1;
    gen(SRC_G, 8, 8'h0F);
    g_req = 1'b1;
    step();
    g_req = 1'b0;
    expect_frame(SRC_G);
    wait_beats(8, 200);
    repeat (3) step();
    bp_en = 1'b0;
    compare_stream("g_bp");
    check_counters("g_bp");
    check("g_bp_occ_le_depth", 80'(max_occ <= DEPTH), 80'(1));
    check("g_bp_overflow", 80'(err_overflow), 80'(0));

    // A/B round-robin, both offering 4 frames of 3 beats
    gaps.delete();
    for (int i = 0; i < 4; i++) begin
      gen(SRC_A, 3, 8'($urandom_range(1, 255)));
      gen(SRC_B, 3, 8'($urandom_range(1, 255)));
    end
    model_arbitrate(4, 4);
    wait_beats(24, 200);
    repeat (3) step();
    compare_stream("rr");
    check_counters("rr");
    check("rr_cnt_equal", 80'(cnt_a), 80'(cnt_b));
    check("rr_gap_count", 80'(gaps.size()), 80'(8));
    for (int i = 1; i < gaps.size(); i++)
      check("rr_gap", 80'(gaps[i]), 80'(2));

    // Priority: g_req during beat 2 of a B frame, A also waiting
    gen(SRC_B, 5, 8'h3F);
    wait_beats(1, 20);
    step();
    g_req = 1'b1;
    gen(SRC_A, 3, 8'h01);
    gen(SRC_G, 8, 8'h0F);
    step();
    g_req = 1'b0;
    expect_frame(SRC_B);
    expect_frame(SRC_G);
    expect_frame(SRC_A);
    wait_beats(16, 300);
    repeat (3) step();
    compare_stream("prio");
    check_counters("prio");

    // Timeout: G never answers its grant, A waits behind it
    grant_seen = 1'b0;
    tmo_pulses = 0;
    g_req = 1'b1;
    step();
    g_req = 1'b0;
    repeat (3) step();
    gen(SRC_A, 2, 8'h07);
    expect_frame(SRC_A);
    wait_beats(2, 150);
    repeat (3) step();
    compare_stream("tmo");
    check_counters("tmo");
    check("tmo_grant_seen", 80'(grant_seen), 80'(1));
    check("tmo_latency", 80'(tmo_cyc - grant_cyc), 80'(TMO));
    check("tmo_pulses", 80'(tmo_pulses), 80'(1));
    check("tmo_grant_low", 80'(tmo_grant), 80'(0));

    // Reset during beat 3 of a G frame
    gen(SRC_G, 8, 8'h0F);
    g_req = 1'b1;
    step();
    g_req = 1'b0;
    wait_beats(2, 50);
    step();
    aresetn = 1'b0;
    #1;
    exp_cnt_g = '0; exp_cnt_a = '0; exp_cnt_b = '0;
    check_reset_outputs("midrst");
    g_q.delete(); pg_q.delete(); obs_q.delete(); exp_q.delete();
    in_frame = 1'b0;
    repeat (2) step();
    aresetn = 1'b1;
    step();
    gen(SRC_G, 8, 8'h0F);
    g_req = 1'b1;
    step();
    g_req = 1'b0;
    expect_frame(SRC_G);
    wait_beats(8, 100);
    repeat (3) step();
    compare_stream("post_rst");
    check_counters("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
